alu_nibble_seq: RTL

//  Parametrised nibble-serial ALU engine, successor to the fixed 8-bit two-pass ALU datapath.

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_nibble_core.sv | 41 ++++
 rtl/alu_nibble_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the nibble-serial ALU.
//   alu_op_t      : 3-bit operation code (ADD ADC SUB SBC AND XOR OR CP)
//   FLAG_*        : bit positions inside the Z80-format flag byte {S,Z,Y,H,X,PV,N,C}
//   is_sub/is_logic : operation class helpers used by the slice and the flag logic
package alu_seq_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_ADC = 3'd1, OP_SUB = 3'd2, OP_SBC = 3'd3,
    OP_AND = 3'd4, OP_XOR = 3'd5, OP_OR  = 3'd6, OP_CP  = 3'd7
  } alu_op_t;

  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_Y  = 5;
  localparam int FLAG_H  = 4;
  localparam int FLAG_X  = 3;
  localparam int FLAG_PV = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 0;

  function automatic logic is_sub(input alu_op_t op);
    return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
  endfunction

  function automatic logic is_logic(input alu_op_t op);
    return (op == OP_AND) || (op == OP_XOR) || (op == OP_OR);
  endfunction
endpackage

// File: rtl/alu_nibble_core.sv
// Combinational 4-bit ALU slice.
//   a, b  : operand slices
//   cin   : carry into bit 0 of the slice (raw carry, subtracts already use A + ~B + ~borrow)
//   op    : operation
//   res   : slice result
//   c3    : carry into bit 3 (needed for overflow on the top slice)
//   cout  : carry out of bit 3
//   par   : xor of the result bits (odd parity)
module alu_nibble_core
  import alu_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  alu_op_t    op,
  output logic [3:0] res,
  output logic       c3,
  output logic       cout,
  output logic       par
);
  logic [3:0] b_eff;
  logic [4:0] sum;

  assign b_eff = is_sub(op) ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {4'b0, cin};

  always_comb begin
    res  = sum[3:0];
    // carry into bit 3 recovered from the sum bit and its two inputs
    c3   = a[3] ^ b_eff[3] ^ sum[3];
    cout = sum[4];
    case (op)
      OP_AND: begin res = a & b; c3 = 1'b0; cout = 1'b0; end
      OP_XOR: begin res = a ^ b; c3 = 1'b0; cout = 1'b0; end
      OP_OR:  begin res = a | b; c3 = 1'b0; cout = 1'b0; end
      default: ;
    endcase
  end

  assign par = ^res;
endmodule

// File: rtl/alu_nibble_seq.sv
// Nibble-serial ALU: one 4-bit slice per clock, low to high, NIBBLES cycles per op.
//   clk, reset   : clock, asynchronous active-high reset
//   start        : request, taken only while idle (including the done cycle)
//   op, cf_in    : operation and carry/borrow-in, sampled with start
//   op_a, op_b   : operands, sampled with start
//   busy         : operation in progress
//   done         : one-cycle pulse with result/flags valid
//   result,flags : held until the next completion; flags = {S,Z,Y,H,X,PV,N,C}
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cf_in,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [7:0]       flags
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  alu_op_t          op_q;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             carry, z_acc, p_acc;

  logic [3:0]       s_res;
  logic             s_c3, s_cout, s_par;
  logic [WIDTH-1:0] a_rot, b_rot, res_nxt, xy_src;
  logic             z_nxt, p_nxt, cin0;
  logic [7:0]       fl_nxt;

  alu_nibble_core u_core (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .op   (op_q),
    .res  (s_res),
    .c3   (s_c3),
    .cout (s_cout),
    .par  (s_par)
  );

  // Operands rotate rather than shift, so after the last slice they are back
  // to their original values: CP needs op_a as result and op_b for Y/X.
  assign a_rot   = {a_sh[3:0], a_sh[WIDTH-1:4]};
  assign b_rot   = {b_sh[3:0], b_sh[WIDTH-1:4]};
  assign res_nxt = {s_res, res_sh[WIDTH-1:4]};
  assign z_nxt   = z_acc & (s_res == 4'h0);
  assign p_nxt   = p_acc ^ s_par;

  // Slice-0 raw carry: subtracts add ~B, so "no borrow" is a carry of 1.
  always_comb begin
    cin0 = 1'b0;
    case (alu_op_t'(op))
      OP_ADC:        cin0 = cf_in;
      OP_SUB, OP_CP: cin0 = 1'b1;
      OP_SBC:        cin0 = ~cf_in;
      default:       cin0 = 1'b0;
    endcase
  end

  // Final flags, evaluated while the top slice is on the core.
  always_comb begin
    fl_nxt = '0;
    xy_src = (op_q == OP_CP) ? b_rot : res_nxt;
    fl_nxt[FLAG_S] = res_nxt[WIDTH-1];
    fl_nxt[FLAG_Z] = z_nxt;
    fl_nxt[FLAG_Y] = xy_src[WIDTH-3];
    fl_nxt[FLAG_X] = xy_src[WIDTH-5];
    fl_nxt[FLAG_N] = is_sub(op_q);
    if (is_logic(op_q)) begin
      fl_nxt[FLAG_H]  = (op_q == OP_AND);
      fl_nxt[FLAG_PV] = ~p_nxt;
    end else begin
      // carry reg currently holds the carry into the top nibble
      fl_nxt[FLAG_H]  = carry ^ is_sub(op_q);
      fl_nxt[FLAG_PV] = s_c3 ^ s_cout;
      fl_nxt[FLAG_C]  = s_cout ^ is_sub(op_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      op_q   <= OP_ADD;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      z_acc  <= 1'b0;
      p_acc  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q   <= alu_op_t'(op);
          a_sh   <= op_a;
          b_sh   <= op_b;
          res_sh <= '0;
          carry  <= cin0;
          z_acc  <= 1'b1;
          p_acc  <= 1'b0;
          idx    <= '0;
          busy   <= 1'b1;
          state  <= RUN;
        end
        RUN: begin
          a_sh   <= a_rot;
          b_sh   <= b_rot;
          res_sh <= res_nxt;
          carry  <= s_cout;
          z_acc  <= z_nxt;
          p_acc  <= p_nxt;
          idx    <= idx + IW'(1);
          if (idx == LAST) begin
            result <= (op_q == OP_CP) ? a_rot : res_nxt;
            flags  <= fl_nxt;
            done   <= 1'b1;
            busy   <= 1'b0;
            idx    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
